// File: rtl/freq_meter_pkg.sv
// Shared types and default widths for the multi-channel frequency meter.
package freq_meter_pkg;

    localparam int unsigned CH_DEF   = 4;
    localparam int unsigned CW_DEF   = 32;
    localparam int unsigned GW_DEF   = 27;
    localparam int unsigned SYNC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/freq_meter_chan.sv
// One measurement channel: input synchronizer, rising-edge detect and a
// saturating edge counter with a sticky overflow bit.
module freq_meter_chan
    import freq_meter_pkg::*;
#(
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Fx,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          ovf
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   rise_c;

    assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], Fx};
        prev_d  = sync_q[SYNC_STAGES-1];
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (en && rise_c) begin
            // Saturate instead of wrapping; the lost edge marks the overflow.
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel gate-and-count frequency meter: shared gate timer and FSM,
// per-channel counters, and a simultaneous latch of all results per window.
module freq_meter_mc
    import freq_meter_pkg::*;
#(
    parameter int unsigned CH          = CH_DEF,
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned GW          = GW_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [CH-1:0]    Fxin,
    input  logic             Enable,
    input  logic [GW-1:0]    Gate_Len,
    output logic [CH*CW-1:0] Frequency,
    output logic [CH-1:0]    Overflow,
    output logic             Valid,
    output logic             Gate_Active
);

    state_e             state_q, state_d;
    logic [GW-1:0]      timer_q, timer_d;
    logic [CH*CW-1:0]   freq_q, freq_d;
    logic [CH-1:0]      ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               gate_active_q, gate_active_d;

    logic [CH*CW-1:0]   cnt_all;
    logic [CH-1:0]      cnt_ovf;
    logic               chan_en;
    logic               chan_clr;

    // Counters run only inside an enabled gate; any other cycle clears them.
    assign chan_en  = (state_q == ST_GATE);
    assign chan_clr = (state_q != ST_GATE) || !Enable;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        freq_meter_chan #(
            .CW          (CW),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .Clk   (Clk),
            .Rst   (Rst),
            .Fx    (Fxin[i]),
            .clr   (chan_clr),
            .en    (chan_en),
            .count (cnt_all[i*CW +: CW]),
            .ovf   (cnt_ovf[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        freq_d   = freq_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    timer_d = Gate_Len;
                    state_d = ST_GATE;
                end
            end
            ST_GATE: begin
                // Dropping Enable abandons the window without touching results.
                if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    timer_d = timer_q - GW'(1);
                end
            end
            ST_LATCH: begin
                freq_d  = cnt_all;
                ovf_d   = cnt_ovf;
                valid_d = 1'b1;
                if (Enable) begin
                    timer_d = Gate_Len;
                    state_d = ST_GATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gate_active_d = (state_d == ST_GATE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            freq_q        <= '0;
            ovf_q         <= '0;
            valid_q       <= 1'b0;
            gate_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            freq_q        <= freq_d;
            ovf_q         <= ovf_d;
            valid_q       <= valid_d;
            gate_active_q <= gate_active_d;
        end
    end

    assign Frequency   = freq_q;
    assign Overflow    = ovf_q;
    assign Valid       = valid_q;
    assign Gate_Active = gate_active_q;

endmodule
